// File: rtl/sysid_boot_checker.sv
// Boot-time Avalon-MM reader for the sysid slave: reads ID and timestamp words,
// compares them, and reports pass/fail/timeout with a shared per-check retry budget.
module sysid_boot_checker #(
    parameter logic [31:0] EXP_ID      = 32'h0000_0000,
    parameter logic [31:0] EXP_TS      = 32'd1427239117,
    parameter bit          CHECK_TS    = 1'b1,
    parameter logic [7:0]  TIMEOUT_CYC = 8'd255,
    parameter int          MAX_RETRY   = 3,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    input  logic        i_avm_readdatavalid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_id_ok,
    output logic        o_ts_ok,
    output logic        o_timeout_err,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value
);
    // state      | meaning
    // S_IDLE     | waiting for start or the armed post-reset auto-start
    // S_RD_ID/TS | read command for word 0/1 presented, held while stalled
    // S_WT_ID/TS | command accepted, waiting for readdatavalid
    // S_CHECK    | compare captured words, pulse done
    // S_FAIL_TO  | retry budget exhausted, flag timeout, pulse done
    typedef enum logic [2:0] {
        S_IDLE, S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS, S_CHECK, S_FAIL_TO
    } state_t;

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t        r_state, w_next;
    logic [7:0]    r_to_cnt;
    logic [RW-1:0] r_retry;
    logic          r_arm, r_busy, r_done, r_id_ok, r_ts_ok, r_to_err;
    logic [31:0]   r_id_value, r_ts_value;

    logic w_rd, w_wt, w_word, w_go, w_accept, w_tc, w_expire;
    logic w_enter_rd, w_retry_inc, w_cap_id, w_cap_ts;

    assign w_rd     = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_wt     = (r_state == S_WT_ID) || (r_state == S_WT_TS);
    assign w_word   = (r_state == S_RD_TS) || (r_state == S_WT_TS);
    assign w_go     = (r_state == S_IDLE) && ((i_start && !r_done) || r_arm);
    assign w_accept = w_rd && !i_avm_waitrequest;
    assign w_tc     = (r_to_cnt == TIMEOUT_CYC);
    // Data arriving on the terminal-count cycle still counts as success.
    assign w_expire = w_tc && ((w_rd && !w_accept) || (w_wt && !i_avm_readdatavalid));

    assign o_avm_read    = w_rd;
    assign o_avm_address = (r_state == S_RD_TS);
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_id_ok       = r_id_ok;
    assign o_ts_ok       = r_ts_ok;
    assign o_timeout_err = r_to_err;
    assign o_id_value    = r_id_value;
    assign o_ts_value    = r_ts_value;

    always_comb begin
        w_next      = r_state;
        w_enter_rd  = 1'b0;
        w_retry_inc = 1'b0;
        w_cap_id    = 1'b0;
        w_cap_ts    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_next     = S_RD_ID;
                    w_enter_rd = 1'b1;
                end
            end
            S_RD_ID: if (w_accept) w_next = S_WT_ID;
            S_RD_TS: if (w_accept) w_next = S_WT_TS;
            S_WT_ID: begin
                if (i_avm_readdatavalid) begin
                    w_cap_id   = 1'b1;
                    w_next     = S_RD_TS;
                    w_enter_rd = 1'b1;
                end
            end
            S_WT_TS: begin
                if (i_avm_readdatavalid) begin
                    w_cap_ts = 1'b1;
                    w_next   = S_CHECK;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_expire) begin
            if (r_retry < RETRY_LIM) begin
                w_retry_inc = 1'b1;
                w_enter_rd  = 1'b1;
                w_next      = w_word ? S_RD_TS : S_RD_ID;
            end else begin
                w_next = S_FAIL_TO;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_to_cnt   <= '0;
            r_retry    <= '0;
            r_arm      <= AUTO_START;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_to_err   <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_done <= (r_state == S_CHECK) || (r_state == S_FAIL_TO);
            if (w_enter_rd)                r_to_cnt <= '0;
            else if ((w_rd || w_wt) && !w_tc) r_to_cnt <= r_to_cnt + 8'd1;
            if (w_go) begin
                r_retry  <= '0;
                r_arm    <= 1'b0;
                r_busy   <= 1'b1;
                r_id_ok  <= 1'b0;
                r_ts_ok  <= 1'b0;
                r_to_err <= 1'b0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RW'(1);
            end
            if (w_cap_id) r_id_value <= i_avm_readdata;
            if (w_cap_ts) r_ts_value <= i_avm_readdata;
            if (r_state == S_CHECK) begin
                r_busy  <= 1'b0;
                r_id_ok <= (r_id_value == EXP_ID);
                r_ts_ok <= (r_ts_value == EXP_TS) || !CHECK_TS;
            end
            if (r_state == S_FAIL_TO) begin
                r_busy   <= 1'b0;
                r_to_err <= 1'b1;
                r_id_ok  <= 1'b0;
                r_ts_ok  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: scripted sysid slave, per-check arithmetic outcome model,
// and a per-cycle compare of two instances (timestamp checked / ignored).
module tb_sysid_boot_checker;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1427239117;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        waitreq = 1'b0;
    logic        rvalid  = 1'b0;
    logic [31:0] rdata   = '0;

    logic        a_addr, a_read, a_busy, a_done, a_idok, a_tsok, a_to;
    logic [31:0] a_idv, a_tsv;
    logic        b_addr, b_read, b_busy, b_done, b_idok, b_tsok, b_to;
    logic [31:0] b_idv, b_tsv;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          cfg_wait [2];
    int          cfg_lat  [2];
    int          cfg_nr   [2];
    logic [31:0] cfg_dat  [2];
    int          stray_until = -1;

    int          m_s = -10, m_done = -10, m_acc = 0;
    logic        m_idok = 1'b0, m_tsok_a = 1'b0, m_tsok_b = 1'b0, m_to = 1'b0;
    logic [31:0] m_idv = '0, m_tsv = '0;

    int          obs_done  = -1;
    int          acc_total = 0;

    int          s_rd_cnt = 0, s_due = -1, s_good = 0;
    int          s_acc [2];
    logic [31:0] s_pd = '0;
    logic        s_stalled = 1'b0, s_st_addr = 1'b0;

    sysid_boot_checker dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
        .o_avm_address(a_addr), .o_avm_read(a_read),
        .i_avm_waitrequest(waitreq), .i_avm_readdata(rdata), .i_avm_readdatavalid(rvalid),
        .o_busy(a_busy), .o_done(a_done), .o_id_ok(a_idok), .o_ts_ok(a_tsok),
        .o_timeout_err(a_to), .o_id_value(a_idv), .o_ts_value(a_tsv)
    );

    sysid_boot_checker #(.CHECK_TS(1'b0)) dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
        .o_avm_address(b_addr), .o_avm_read(b_read),
        .i_avm_waitrequest(waitreq), .i_avm_readdata(rdata), .i_avm_readdatavalid(rvalid),
        .o_busy(b_busy), .o_done(b_done), .o_id_ok(b_idok), .o_ts_ok(b_tsok),
        .o_timeout_err(b_to), .o_id_value(b_idv), .o_ts_value(b_tsv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_cfg(input int w0, input int w1, input int l0, input int l1,
                           input int n0, input int n1, input logic [31:0] d0, input logic [31:0] d1);
        cfg_wait[0] = w0; cfg_wait[1] = w1;
        cfg_lat[0]  = l0; cfg_lat[1]  = l1;
        cfg_nr[0]   = n0; cfg_nr[1]   = n1;
        cfg_dat[0]  = d0; cfg_dat[1]  = d1;
    endtask

    task automatic zero_model();
        m_s = -10; m_done = -10;
        m_idok = 1'b0; m_tsok_a = 1'b0; m_tsok_b = 1'b0; m_to = 1'b0;
        m_idv = '0; m_tsv = '0;
    endtask

    // Whole-check outcome: each attempt costs wait+1+lat cycles when answered, 256 when not;
    // three retries are shared by both words. Done is seen two cycles after the last attempt.
    task automatic plan_check(input int s);
        int c, r, acc;
        logic to;
        logic [31:0] v [2];
        c = 0; r = 0; acc = 0; to = 1'b0;
        v[0] = m_idv; v[1] = m_tsv;
        for (int w = 0; w < 2; w++) begin
            if (to) break;
            for (int a = 0; a < 8; a++) begin
                acc++;
                if (a < cfg_nr[w]) begin
                    c += 256;
                    if (r < 3) r++;
                    else begin to = 1'b1; break; end
                end else begin
                    c += cfg_wait[w] + 1 + cfg_lat[w];
                    v[w] = cfg_dat[w];
                    break;
                end
            end
        end
        m_s = s; m_done = s + c + 2; m_acc = acc;
        m_idv = v[0]; m_tsv = v[1]; m_to = to;
        m_idok   = !to && (v[0] == EXP_ID);
        m_tsok_a = !to && (v[1] == EXP_TS);
        m_tsok_b = !to;
    endtask

    task automatic start_check();
        @(posedge clk); #1;
        acc_total = 0; obs_done = -1;
        start = 1'b1;
        plan_check(cyc);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_check(input logic busy_poke, input logic done_poke);
        while (cyc < m_done) begin
            start = busy_poke && (cyc == m_s + 3);
            @(posedge clk); #1;
        end
        start = done_poke;
        @(negedge clk); #1;
        chk("done_seen", obs_done, m_done);
        chk("accepts", acc_total, m_acc);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic reset_mid(input int w1, input int l1, input int off);
        set_cfg(0, w1, 1, l1, 0, 0, EXP_ID, EXP_TS);
        start_check();
        while (cyc < m_s + off) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        zero_model();
        #1;
        chk("async_read_drop", a_read, 0);
        chk("async_busy_clr", {a_busy, b_busy}, 0);
        repeat (2) begin @(posedge clk); #1; end
        set_cfg(0, 0, 1, 1, 0, 0, EXP_ID, EXP_TS);
        obs_done = -1; acc_total = 0;
        stray_until = cyc + 2;
        rst_n = 1'b1;
        plan_check(cyc);
        finish_check(1'b0, 1'b0);
        chk("rst_rerun_latency", obs_done - m_s, 6);
        chk("rst_rerun_pass", {a_idok, a_tsok, a_to}, 3'b110);
    endtask

    // sysid slave: stalls each command cfg_wait cycles, answers cfg_lat cycles after
    // acceptance, and leaves the first cfg_nr commands of each word unanswered.
    initial begin
        s_acc[0] = 0; s_acc[1] = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                s_rd_cnt = 0; s_due = -1; s_good = 0; s_stalled = 1'b0;
                s_acc[0] = 0; s_acc[1] = 0;
                waitreq = 1'b0; rvalid = 1'b0;
            end else begin
                int w;
                if (!a_busy) begin s_acc[0] = 0; s_acc[1] = 0; s_good = 0; end
                if (s_stalled) begin
                    chk("stall_read_held", a_read, 1);
                    chk("stall_addr_held", a_addr, s_st_addr);
                end
                s_stalled = 1'b0; waitreq = 1'b0; rvalid = 1'b0; rdata = $urandom;
                if (cyc == s_due) begin
                    rvalid = 1'b1; rdata = s_pd; s_good++; s_due = -1;
                end else if (cyc < stray_until) begin
                    rvalid = 1'b1;
                end
                if (a_read) begin
                    chk("rd_addr", a_addr, s_good);
                    w = a_addr ? 1 : 0;
                    if (s_rd_cnt < cfg_wait[w]) begin
                        waitreq = 1'b1; s_rd_cnt++; s_stalled = 1'b1; s_st_addr = a_addr;
                    end else begin
                        s_rd_cnt = 0; acc_total++;
                        if (s_acc[w] >= cfg_nr[w]) begin
                            s_due = cyc + cfg_lat[w]; s_pd = cfg_dat[w];
                        end
                        s_acc[w]++;
                    end
                end else begin
                    s_rd_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic eb, ed;
        if (!rst_n) begin
            chk("rst_read_addr", {a_read, a_addr, b_read, b_addr}, 0);
            chk("rst_busy_done", {a_busy, a_done, b_busy, b_done}, 0);
            chk("rst_status", {a_idok, a_tsok, a_to, b_idok, b_tsok, b_to}, 0);
            chk("rst_values", {a_idv, a_tsv}, 0);
        end else begin
            eb = (cyc > m_s) && (cyc < m_done);
            ed = (cyc == m_done);
            chk("busy", {a_busy, b_busy}, {eb, eb});
            chk("done", {a_done, b_done}, {ed, ed});
            if (cyc >= m_done) begin
                chk("status_a", {a_idok, a_tsok, a_to}, {m_idok, m_tsok_a, m_to});
                chk("status_b", {b_idok, b_tsok, b_to}, {m_idok, m_tsok_b, m_to});
                chk("id_value", {a_idv, b_idv}, {m_idv, m_idv});
                chk("ts_value", {a_tsv, b_tsv}, {m_tsv, m_tsv});
            end else if (eb) begin
                chk("status_cleared", {a_idok, a_tsok, a_to, b_idok, b_tsok, b_to}, 0);
            end
            if (a_done) obs_done = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        set_cfg(0, 0, 1, 1, 0, 0, EXP_ID, EXP_TS);
        zero_model();
        repeat (3) begin @(posedge clk); #1; end
        obs_done = -1; acc_total = 0;
        rst_n = 1'b1;
        plan_check(cyc);
        finish_check(1'b0, 1'b0);
        chk("t1_latency", obs_done - m_s, 6);
        chk("t1_pass", {a_idok, a_tsok, a_to}, 3'b110);

        set_cfg(0, 0, 1, 1, 0, 0, 32'h1, EXP_TS);
        start_check(); finish_check(1'b1, 1'b1);
        chk("t2_status", {a_idok, a_tsok, a_to}, 3'b010);
        chk("t2_id_value", a_idv, 32'h1);

        set_cfg(0, 5, 1, 1, 0, 0, EXP_ID, EXP_TS);
        start_check(); finish_check(1'b0, 1'b0);
        chk("t3_latency", obs_done - m_s, 11);
        chk("t3_pass", {a_idok, a_tsok}, 2'b11);

        set_cfg(0, 0, 1, 1, 4, 0, EXP_ID, EXP_TS);
        start_check(); finish_check(1'b0, 1'b0);
        chk("t4_latency", obs_done - m_s, 1026);
        chk("t4_timeout", {a_idok, a_tsok, a_to}, 3'b001);
        chk("t4_attempts", acc_total, 4);

        set_cfg(0, 0, 1, 1, 0, 0, EXP_ID, 32'hDEAD_BEEF);
        start_check(); finish_check(1'b0, 1'b0);
        chk("t5_ts_ignored", {b_tsok, a_tsok}, 2'b10);
        chk("t5_ts_value", b_tsv, 32'hDEAD_BEEF);

        set_cfg(3, 0, 252, 1, 0, 0, EXP_ID, EXP_TS);
        start_check(); finish_check(1'b0, 1'b0);
        chk("edge_data_wins_latency", obs_done - m_s, 260);
        chk("edge_data_wins_attempts", acc_total, 2);

        set_cfg(0, 0, 1, 1, 2, 1, EXP_ID, EXP_TS);
        start_check(); finish_check(1'b0, 1'b0);
        chk("retry_ok_latency", obs_done - m_s, 774);
        chk("retry_ok_status", {a_idok, a_tsok, a_to}, 3'b110);

        set_cfg(0, 0, 1, 1, 1, 3, 32'h1234, EXP_TS);
        start_check(); finish_check(1'b0, 1'b0);
        chk("retry_exhaust_latency", obs_done - m_s, 1028);
        chk("retry_exhaust_status", {a_idok, a_to, a_idv}, {2'b01, 32'h1234});

        reset_mid(6, 1, 5);
        reset_mid(0, 4, 5);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] d0, d1;
            case ($urandom_range(0, 2))
                0:       d0 = EXP_ID;
                1:       d0 = 32'h1;
                default: d0 = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       d1 = EXP_TS;
                1:       d1 = 32'hDEAD_BEEF;
                default: d1 = $urandom;
            endcase
            set_cfg($urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(1, 4), $urandom_range(1, 4),
                    ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0,
                    d0, d1);
            start_check();
            finish_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
